// File: rtl/pipe_stage_elastic.sv
// Inter-stage pipeline buffer carrying an opaque WIDTH-bit payload.
// DEPTH=1 acts as a plain pipeline register; DEPTH>=2 acts as an elastic FIFO with registered in_ready.
module pipe_stage_elastic #(
  parameter int               WIDTH        = 32,
  parameter int               DEPTH        = 1,
  parameter logic [WIDTH-1:0] RESET_VAL    = '0,
  parameter int               MASK_INVALID = 1,
  parameter int               CNT_W        = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [CNT_W-1:0]             stall_cnt,
  input  logic                         stall_clr
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic             push, pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == LAST) ? '0 : ptr + PW'(1);
  endfunction

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign push      = in_valid & in_ready & ~flush;

  // A single register may refill on the same edge it drains; the FIFO keeps
  // in_ready purely registered so out_ready never reaches the upstream stage.
  generate
    if (DEPTH == 1) begin : g_reg
      assign in_ready = (count < FULL) | out_ready;
    end else begin : g_fifo
      assign in_ready = (count < FULL);
    end
  endgenerate

  assign out_data = ((MASK_INVALID != 0) && !out_valid) ? '0 : mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: payload storage is reset on purpose so out_data is RESET_VAL-defined when unmasked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
    end else if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Flush leaves the stall statistic untouched; clear beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall_clr) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
